fmul_pipe: RTL and testbench

Parametrised, pipelined floating-point multiplier; successor to the team's combinational single-precision `fmul`. It accepts one operand pair per cycle over a valid/ready handshake and returns the product three cycles later. Unlike `fmul`, it adds:
- selectable round-to-nearest-even or truncation;
- handling of infinities, NaNs, overflow and underflow, reported on exception flags;
- full-pipeline backpressure.

It sits between the FPU operand-issue logic and the result writeback arbiter.

---
 rtl/fmul_pipe.sv | 164 ++++++++++++++++
 tb/tb_fmul_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Three-stage pipelined FP multiplier (classify/multiply, normalise/round, exponent/pack); latency 3, 1/cycle.
// Backpressure: all stages hold while out_valid & !out_ready; in_ready mirrors the shared advance enable.
module fmul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter bit RNE   = 1'b1,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic [2:0]   out_flags
);

  localparam int PW = 2*MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W+1:0] BIAS_X = (EXP_W+2)'((1 << (EXP_W-1)) - 1);
  localparam logic [1:0] K_FIN = 2'd0, K_NAN = 2'd1, K_INF = 2'd2, K_ZERO = 2'd3;

  logic             r1_vld, r2_vld, r3_vld;
  logic             r1_sign, r2_sign;
  logic [1:0]       r1_kind, r2_kind;
  logic [EXP_W:0]   r1_esum, r2_esum;
  logic [PW-1:0]    r1_prod;
  logic [MAN_W-1:0] r2_man;
  logic [1:0]       r2_adj;
  logic [W-1:0]     r3_y;
  logic [2:0]       r3_flags;

  logic w_en;
  assign w_en      = !r3_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r3_vld;
  assign out_y     = r3_y;
  assign out_flags = r3_flags;

  // Stage 1: classify operands and form the full mantissa product.
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic             w_za, w_zb, w_ia, w_ib, w_na, w_nb;
  logic [1:0]       w_kind;
  logic [PW-1:0]    w_prod;
  logic [EXP_W:0]   w_esum;

  assign w_ea   = in_a[W-2:MAN_W];
  assign w_eb   = in_b[W-2:MAN_W];
  assign w_ma   = in_a[MAN_W-1:0];
  assign w_mb   = in_b[MAN_W-1:0];
  assign w_za   = (w_ea == '0);
  assign w_zb   = (w_eb == '0);
  assign w_ia   = (w_ea == EMAX) && (w_ma == '0);
  assign w_ib   = (w_eb == EMAX) && (w_mb == '0);
  assign w_na   = (w_ea == EMAX) && (w_ma != '0);
  assign w_nb   = (w_eb == EMAX) && (w_mb != '0);
  assign w_prod = PW'({1'b1, w_ma}) * PW'({1'b1, w_mb});
  assign w_esum = {1'b0, w_ea} + {1'b0, w_eb};

  always_comb begin
    w_kind = K_FIN;
    if (w_na || w_nb || (w_ia && w_zb) || (w_za && w_ib)) w_kind = K_NAN;
    else if (w_ia || w_ib)                                 w_kind = K_INF;
    else if (w_za || w_zb)                                 w_kind = K_ZERO;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_vld  <= 1'b0;
      r1_sign <= 1'b0;
      r1_kind <= K_FIN;
      r1_esum <= '0;
      r1_prod <= '0;
    end else if (w_en) begin
      r1_vld  <= in_valid;
      r1_sign <= in_a[W-1] ^ in_b[W-1];
      r1_kind <= w_kind;
      r1_esum <= w_esum;
      r1_prod <= w_prod;
    end
  end

  // Stage 2: left-justify so the kept field, guard and sticky sit at fixed positions.
  logic             w_a;
  logic [2*MAN_W:0] w_norm;
  logic [MAN_W-1:0] w_kept;
  logic             w_guard, w_sticky, w_inc;
  logic [MAN_W:0]   w_rnd;

  assign w_a      = r1_prod[PW-1];
  assign w_norm   = w_a ? r1_prod[2*MAN_W:0] : {r1_prod[2*MAN_W-1:0], 1'b0};
  assign w_kept   = w_norm[2*MAN_W:MAN_W+1];
  assign w_guard  = w_norm[MAN_W];
  assign w_sticky = |w_norm[MAN_W-1:0];
  assign w_inc    = RNE && w_guard && (w_sticky || w_kept[0]);
  assign w_rnd    = {1'b0, w_kept} + (MAN_W+1)'(w_inc);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_vld  <= 1'b0;
      r2_sign <= 1'b0;
      r2_kind <= K_FIN;
      r2_esum <= '0;
      r2_man  <= '0;
      r2_adj  <= '0;
    end else if (w_en) begin
      r2_vld  <= r1_vld;
      r2_sign <= r1_sign;
      r2_kind <= r1_kind;
      r2_esum <= r1_esum;
      r2_man  <= w_rnd[MAN_W-1:0];
      r2_adj  <= 2'(w_a) + 2'(w_rnd[MAN_W]);
    end
  end

  // Stage 3: biased exponent with range checks, then special-case override.
  logic [EXP_W+1:0] w_ey;
  logic             w_of, w_uf;
  logic [W-1:0]     w_y;
  logic [2:0]       w_flags;

  assign w_ey = {1'b0, r2_esum} + (EXP_W+2)'(r2_adj) - BIAS_X;
  assign w_of = !w_ey[EXP_W+1] && (w_ey >= {2'b00, EMAX});
  assign w_uf = w_ey[EXP_W+1] || (w_ey == '0);

  always_comb begin
    w_y     = {r2_sign, w_ey[EXP_W-1:0], r2_man};
    w_flags = 3'b000;
    case (r2_kind)
      K_NAN: begin
        w_y     = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        w_flags = 3'b100;
      end
      K_INF:  w_y = {r2_sign, EMAX, {MAN_W{1'b0}}};
      K_ZERO: w_y = {r2_sign, {(W-1){1'b0}}};
      default: begin
        if (w_of) begin
          w_y     = {r2_sign, EMAX, {MAN_W{1'b0}}};
          w_flags = 3'b010;
        end else if (w_uf) begin
          w_y     = {r2_sign, {(W-1){1'b0}}};
          w_flags = 3'b001;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r3_vld   <= 1'b0;
      r3_y     <= '0;
      r3_flags <= 3'b000;
    end else if (w_en) begin
      r3_vld   <= r2_vld;
      r3_y     <= w_y;
      r3_flags <= r2_vld ? w_flags : 3'b000;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: directed cases, backpressure, reset mid-stall and a randomized stream
// against an arithmetic reference model; an RNE=0 instance shares the stimulus for truncation.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn, in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, t_in_ready, t_out_valid;
  logic [31:0] out_y, t_out_y;
  logic [2:0]  out_flags, t_out_flags;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .RNE(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags));

  fmul_pipe #(.EXP_W(8), .MAN_W(23), .RNE(1'b0)) dut_t (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(t_in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_y(t_out_y), .out_flags(t_out_flags));

  // Reference: {flags[2:0], y[31:0]} from value arithmetic (remainder vs half-ulp rounding).
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit rne);
    int ea, eb, e, sh;
    longint p, q, rem, half;
    logic s, za, zb, ia, ib, na, nb;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (za && ib)) return {3'b100, 32'h7FC00000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, s, 31'h0};
    p  = (longint'(a[22:0]) + 64'sd8388608) * (longint'(b[22:0]) + 64'sd8388608);
    e  = ea + eb - 127;
    sh = 23;
    if (p >= 64'sd140737488355328) begin
      sh = 24;
      e  = e + 1;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rne && ((rem > half) || (rem == half && q[0]))) q = q + 1;
    if (q >= 64'sd16777216) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    if (sel < 8)       r[30:23] = 8'($urandom_range(20, 235));
    else if (sel == 8) r[30:23] = 8'h00;
    else               r[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h7F;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation with out_ready high; returns what sits on the outputs 3 cycles later.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic v,
                        output logic [31:0] y, output logic [2:0] f,
                        output logic [31:0] yt, output logic [2:0] ft);
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    v = out_valid; y = out_y; f = out_flags; yt = t_out_y; ft = t_out_flags;
    step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_y !== 32'h0) begin errors++; $display("FAIL reset_y got=%h exp=0", out_y); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", out_flags); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_basic();
    logic v; logic [31:0] y, yt; logic [2:0] f, ft;
    run_op(32'h3FC00000, 32'h40000000, v, y, f, yt, ft);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", v); end
    checks++; if (y !== 32'h40400000) begin errors++; $display("FAIL basic_y got=%h exp=40400000", y); end
    checks++; if (f !== 3'b000) begin errors++; $display("FAIL basic_flags got=%b exp=000", f); end
    run_op(32'h40000000, 32'h3FC00000, v, y, f, yt, ft);
    checks++; if (y !== 32'h40400000 || v !== 1'b1) begin
      errors++; $display("FAIL basic_swap got=%h vld=%b exp=40400000", y, v); end
  endtask

  task automatic test_rounding();
    logic v; logic [31:0] y, yt; logic [2:0] f, ft;
    run_op(32'h3F800001, 32'h3FC00000, v, y, f, yt, ft);
    checks++; if (y !== 32'h3FC00002) begin errors++; $display("FAIL round_rne got=%h exp=3FC00002", y); end
    checks++; if (yt !== 32'h3FC00001) begin errors++; $display("FAIL round_trunc got=%h exp=3FC00001", yt); end
    checks++; if (f !== 3'b000 || ft !== 3'b000) begin
      errors++; $display("FAIL round_flags got=%b/%b exp=000/000", f, ft); end
  endtask

  task automatic test_range();
    logic [98:0] tbl [3] = '{
      {32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010},
      {32'h00800000, 32'h00800000, 32'h00000000, 3'b001},
      {32'h80800000, 32'h00800000, 32'h80000000, 3'b001}};
    logic v; logic [31:0] y, yt; logic [2:0] f, ft;
    for (int i = 0; i < 3; i++) begin
      run_op(tbl[i][98:67], tbl[i][66:35], v, y, f, yt, ft);
      checks++; if (y !== tbl[i][34:3] || f !== tbl[i][2:0]) begin
        errors++; $display("FAIL range_%0d got=%h/%b exp=%h/%b", i, y, f, tbl[i][34:3], tbl[i][2:0]); end
    end
  endtask

  task automatic test_special();
    logic [98:0] tbl [3] = '{
      {32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100},
      {32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000},
      {32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100}};
    logic v; logic [31:0] y, yt; logic [2:0] f, ft;
    for (int i = 0; i < 3; i++) begin
      run_op(tbl[i][98:67], tbl[i][66:35], v, y, f, yt, ft);
      checks++; if (y !== tbl[i][34:3] || f !== tbl[i][2:0]) begin
        errors++; $display("FAIL special_%0d got=%h/%b exp=%h/%b", i, y, f, tbl[i][34:3], tbl[i][2:0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] kval [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] held = '0;
    bit stalled = 1'b0;
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = !(c >= 4 && c < 8);
      in_valid  = (sent < 6);
      in_a      = 32'h3F800000;
      in_b      = kval[(sent < 6) ? sent : 5];
      #1;
      checks++; if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, !(out_valid && !out_ready)); end
      if (out_valid && !out_ready) begin
        if (stalled) begin
          checks++; if (out_y !== held) begin errors++; $display("FAIL bp_hold got=%h exp=%h", out_y, held); end
        end
        held = out_y; stalled = 1'b1;
      end else stalled = 1'b0;
      if (out_valid && out_ready) begin
        checks++; if (out_y !== kval[got]) begin
          errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", got, out_y, kval[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got vld=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000;
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%b exp=1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_y !== 32'h0 || out_flags !== 3'b000) begin
      errors++; $display("FAIL rst_async got vld=%b y=%h f=%b exp 0/0/0", out_valid, out_y, out_flags); end
    step();
    rstn = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h40000000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_lat1 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_lat2 got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_y !== 32'h40C00000) begin
      errors++; $display("FAIL rst_lat3 got vld=%b y=%h exp 1/40C00000", out_valid, out_y); end
    step();
  endtask

  task automatic test_random();
    logic [34:0] q1 [$];
    logic [34:0] q0 [$];
    logic [34:0] e1, e0;
    for (int c = 0; c < 700; c++) begin
      if (c < 600) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        in_a = rand_op(); in_b = rand_op();
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      checks++; if (t_out_valid !== out_valid || t_in_ready !== in_ready) begin
        errors++; $display("FAIL rand_trunc_hs got=%b%b exp=%b%b", t_out_valid, t_in_ready, out_valid, in_ready); end
      if (out_valid && out_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL rand_extra got=%h exp=none", out_y);
        end else begin
          e1 = q1.pop_front(); e0 = q0.pop_front();
          if ({out_flags, out_y} !== e1) begin
            errors++; $display("FAIL rand_rne got=%b/%h exp=%b/%h", out_flags, out_y, e1[34:32], e1[31:0]); end
          checks++; if ({t_out_flags, t_out_y} !== e0) begin
            errors++; $display("FAIL rand_trunc got=%b/%h exp=%b/%h", t_out_flags, t_out_y, e0[34:32], e0[31:0]); end
        end
      end
      if (in_valid && in_ready) begin
        q1.push_back(ref_mul(in_a, in_b, 1'b1));
        q0.push_back(ref_mul(in_a, in_b, 1'b0));
      end
      step();
    end
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL rand_lost got=%0d pending exp=0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_special();
    test_backpressure();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
